axil_timer_core: RTL and testbench
==================================

// Module: axil_timer_core
// PURPOSE
//  Timer/PWM peripheral core that consumes the register vector produced by axil_reg_if.
//  Register map: CTRL, LOAD, PRESCALE, COMPARE.
//  Provides a prescaled down-counter with one-shot or auto-reload modes, a sticky expiry
//  interrupt, and a compare-based PWM output.
//  Returns COUNT and STATUS words for the read-back path of axil_reg_if.
// PARAMETERS
//  N_REGS     8   width of the incoming register vector, in 32-bit words; must be >= 4
//  PSC_WIDTH  16  width of the prescaler; only PRESCALE[PSC_WIDTH-1:0] is used
// PORTS
//  clk         in   1          system clock; all logic on rising edge
//  rst         in   1          synchronous, active-low reset
//  regs_in     in   N_REGS*32  register vector from axil_reg_if.regs_out; word i = bits [32i+31:32i]
//  reg_wr      in   N_REGS     one-cycle pulse per word, asserted the cycle after that word is written
//  count_out   out  32         current counter value
//  status_out  out  32         {28'b0, state[1:0], running, irq_pending}
//  irq         out  1          interrupt request, level
//  pwm_out     out  1          PWM output, registered
// BEHAVIOUR
//  Register words
//   - Word 0 CTRL:
//     - bit0 EN
//     - bit1 AUTO_RELOAD
//     - bit2 IRQ_EN
//     - bit3 PWM_EN
//     - bit4 IRQ_CLR: acts only when reg_wr[0]=1 and bit4=1
//   - Word 1 LOAD.
//   - Word 2 PRESCALE.
//   - Word 3 COMPARE.
//   - Words 4..N_REGS-1 are ignored.
//  Reset (rst=0 at a clk edge)
//   - state=IDLE, cnt=0, psc_cnt=0, irq_pending=0, pwm_out=0, irq=0.
//   - Reset is honoured in every state, including mid-count.
//  Prescaler
//   - In RUN, psc_cnt increments each cycle.
//   - When psc_cnt==PRESCALE, tick=1 and psc_cnt<=0.
//   - PRESCALE=0 gives tick every cycle.
//   - psc_cnt<=0 on any RUN entry.
//  State machine (2-bit encoding: IDLE=0, RUN=1, DONE=2)
//   - IDLE: if EN=1, then cnt<=LOAD, psc_cnt<=0, go to RUN.
//     Otherwise cnt holds (IDLE is pause, not clear).
//   - RUN, EN=0: go to IDLE and cnt holds.
//     Re-enabling reloads from LOAD; there is no resume.
//   - RUN, EN=1, tick, cnt!=0: cnt<=cnt-1.
//   - RUN, EN=1, tick, cnt==0 (expiry):
//     - irq_pending<=1.
//     - AUTO_RELOAD=1: cnt<=LOAD and stay in RUN.
//     - AUTO_RELOAD=0: cnt holds 0 and go to DONE.
//   - DONE: cnt holds; leave to IDLE only when EN=0.
//   - LOAD=0 with AUTO_RELOAD=1: expiry on every tick.
//  Latency
//   - EN written at cycle t is seen as reg_wr[0] at t+1; RUN is entered at t+2.
//   - Mid-run LOAD writes take effect only at the next reload or re-enable.
//   - PRESCALE and COMPARE are sampled live every cycle.
//  Interrupt
//   - irq_pending is sticky.
//   - Cleared by reg_wr[0] with CTRL bit4=1.
//   - Expiry in the same cycle as a clear: set wins and irq_pending stays 1.
//   - irq = irq_pending & IRQ_EN, combinational from registers.
//   - Clearing IRQ_EN masks irq but does not clear pending.
//  PWM
//   - pwm_out <= PWM_EN & (state==RUN) & (cnt < COMPARE), unsigned 32-bit compare.
//   - COMPARE=0 gives constant 0.
//   - COMPARE > LOAD gives constant 1 while in RUN.
//  Arithmetic
//   - cnt is a 32-bit unsigned down-counter that never decrements below 0 (no wrap).
//   - psc_cnt compares as PSC_WIDTH unsigned.
//  Status
//   - running = (state==RUN).
//   - count_out = cnt.
// STRUCTURE
//  Package axil_timer_pkg holds:
//   - CTRL_IDX=0, LOAD_IDX=1, PSC_IDX=2, CMP_IDX=3
//   - CTRL bit positions (EN, AUTO_RELOAD, IRQ_EN, PWM_EN, IRQ_CLR)
//   - the timer state encoding (IDLE, RUN, DONE)
//  Sub-module axil_prescaler (clk, rst, clr, en, limit[PSC_WIDTH-1:0] -> tick).
//  Counter, FSM, IRQ and PWM logic live in this module.
// TESTING
//  1. Reset with rst=0 for 5 cycles -> count_out=0, status_out=0, irq=0, pwm_out=0.
//  2. One-shot: LOAD=5, PRESCALE=0, CTRL=0x5 ->
//     - count steps 5..0, one per cycle
//     - irq rises 1 cycle after count 0 is seen; state=DONE; count_out stays 0.
//  3. Auto-reload with prescale: LOAD=3, PRESCALE=2, CTRL=0x7 ->
//     - expiry every 12 cycles (4 counts x 3 cycles)
//     - IRQ_CLR write (CTRL=0x17) drops irq for the following cycles until the next expiry.
//  4. PWM: LOAD=9, PRESCALE=0, COMPARE=4, CTRL=0xB -> pwm_out high 4 of every 10 cycles.
//     COMPARE=0 -> pwm_out stuck at 0.
//  5. Simultaneous events and masking:
//     - IRQ_CLR pulse in the expiry cycle -> irq_pending stays 1.
//     - IRQ_EN=0 with a pending expiry -> irq=0 and status_out[0]=1.
//  6. Pause and reset mid-run:
//     - EN=0 at cnt=7 -> IDLE and count_out holds 7; EN=1 -> reloads LOAD.
//     - rst=0 mid-RUN -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/axil_timer_pkg.sv
// Shared definitions for the timer/PWM core:
// register indices, CTRL bit layout and timer states.
package axil_timer_pkg;

  localparam int CTRL_IDX = 0;
  localparam int LOAD_IDX = 1;
  localparam int PSC_IDX  = 2;
  localparam int CMP_IDX  = 3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_PWM_EN  = 3;
  localparam int CTRL_IRQ_CLR = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tmr_state_e;

  typedef struct packed {
    logic irq_clr;
    logic pwm_en;
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(
    input logic [4:0] w
  );
    ctrl_t c;
    c.en          = w[CTRL_EN];
    c.auto_reload = w[CTRL_AUTO];
    c.irq_en      = w[CTRL_IRQ_EN];
    c.pwm_en      = w[CTRL_PWM_EN];
    c.irq_clr     = w[CTRL_IRQ_CLR];
    return c;
  endfunction

endpackage

// File: rtl/axil_timer_core_prescaler.sv
// Free-running prescaler: ticks when its count
// reaches the live limit, then restarts from zero.
module axil_prescaler #(
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PSC_WIDTH-1:0] limit,
  output logic                 tick
);

  logic [PSC_WIDTH-1:0] psc_cnt;

  assign tick = en & (psc_cnt == limit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      psc_cnt <= '0;
    end else if (clr) begin
      psc_cnt <= '0;
    end else if (en) begin
      psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axil_timer_core.sv
// Timer/PWM core: prescaled down-counter with
// one-shot/auto-reload, sticky irq and compare PWM.
module axil_timer_core
  import axil_timer_pkg::*;
#(
  parameter int N_REGS    = 8,
  parameter int PSC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REGS*32-1:0]  regs_in,
  input  logic [N_REGS-1:0]     reg_wr,
  output logic [31:0]           count_out,
  output logic [31:0]           status_out,
  output logic                  irq,
  output logic                  pwm_out
);

  ctrl_t                ctrl;
  logic [31:0]          load_val;
  logic [31:0]          cmp_val;
  logic [PSC_WIDTH-1:0] psc_limit;

  tmr_state_e  state, state_n;
  logic [31:0] cnt, cnt_n;
  logic        irq_pending, pend_n;
  logic        pwm_n;
  logic        psc_clr;
  logic        tick;
  logic        expire;
  logic        running;

  assign ctrl      = decode_ctrl(regs_in[CTRL_IDX*32 +: 5]);
  assign load_val  = regs_in[LOAD_IDX*32 +: 32];
  assign cmp_val   = regs_in[CMP_IDX*32 +: 32];
  assign psc_limit = regs_in[PSC_IDX*32 +: PSC_WIDTH];

  // Upper CTRL bits and spare words are don't-care.
  logic unused_ok;
  assign unused_ok = ^regs_in ^ ^reg_wr;

  assign running = (state == ST_RUN);

  axil_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_psc (
    .clk  (clk),
    .rst  (rst),
    .clr  (psc_clr),
    .en   (running),
    .limit(psc_limit),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    psc_clr = 1'b0;
    expire  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ctrl.en) begin
          state_n = ST_RUN;
          cnt_n   = load_val;
          psc_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (!ctrl.en) begin
          state_n = ST_IDLE;
        end else if (tick) begin
          if (cnt != 32'd0) begin
            cnt_n = cnt - 32'd1;
          end else begin
            expire = 1'b1;
            if (ctrl.auto_reload) begin
              cnt_n = load_val;
            end else begin
              state_n = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (!ctrl.en) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Expiry beats a same-cycle clear.
  assign pend_n = expire |
    (irq_pending & ~(reg_wr[CTRL_IDX] & ctrl.irq_clr));

  assign pwm_n = ctrl.pwm_en & running & (cnt < cmp_val);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      irq_pending <= 1'b0;
      pwm_out     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      irq_pending <= pend_n;
      pwm_out     <= pwm_n;
    end
  end

  assign irq        = irq_pending & ctrl.irq_en;
  assign count_out  = cnt;
  assign status_out = {28'd0, state, running, irq_pending};

endmodule

// File: tb/tb_axil_timer_core.sv
// Bench for axil_timer_core: vector table, corner
// sequences and a random run against a reference model.
module tb_axil_timer_core;

  localparam int NR = 8;

  logic            clk;
  logic            rst;
  logic [NR*32-1:0] regs_in;
  logic [NR-1:0]   reg_wr;
  logic [31:0]     count_out;
  logic [31:0]     status_out;
  logic            irq;
  logic            pwm_out;

  int checks;
  int failures;

  axil_timer_core #(
    .N_REGS(NR),
    .PSC_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .regs_in   (regs_in),
    .reg_wr    (reg_wr),
    .count_out (count_out),
    .status_out(status_out),
    .irq       (irq),
    .pwm_out   (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: timer behaviour as plain arithmetic.
  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] cnt;
    logic [15:0] ph;
    logic        pend;
    logic        pwm;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_next(
    input mdl_t s,
    input logic r,
    input logic [NR*32-1:0] rg,
    input logic [NR-1:0] wr
  );
    mdl_t n = s;
    logic [31:0] c  = rg[31:0];
    logic [31:0] ld = rg[63:32];
    logic [15:0] pl = rg[79:64];
    logic [31:0] cm = rg[127:96];
    logic ex = 1'b0;
    if (!r) return '0;
    n.pwm = c[3] && (s.st == 2'd1) && (s.cnt < cm);
    if (s.st == 2'd0) begin
      if (c[0]) begin
        n.st = 2'd1; n.cnt = ld; n.ph = 16'd0;
      end
    end else if (s.st == 2'd1) begin
      if (!c[0]) n.st = 2'd0;
      else if (s.ph == pl) begin
        n.ph = 16'd0;
        if (s.cnt != 0) n.cnt = s.cnt - 1;
        else begin
          ex = 1'b1;
          if (c[1]) n.cnt = ld;
          else n.st = 2'd2;
        end
      end else n.ph = s.ph + 16'd1;
    end else begin
      if (!c[0]) n.st = 2'd0;
    end
    if (ex) n.pend = 1'b1;
    else if (wr[0] && c[4]) n.pend = 1'b0;
    return n;
  endfunction

  always @(posedge clk) m <= mdl_next(m, rst, regs_in, reg_wr);

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    regs_in = '0;
    reg_wr = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic set_regs(input logic [31:0] c,
                          input logic [31:0] l,
                          input logic [31:0] p,
                          input logic [31:0] cm);
    regs_in[31:0]   = c;
    regs_in[63:32]  = l;
    regs_in[95:64]  = p;
    regs_in[127:96] = cm;
  endtask

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] load;
    logic [31:0] psc;
    logic [31:0] cmp;
    int          k;
    logic [31:0] e_cnt;
    logic [31:0] e_st;
    logic        e_irq;
    logic        e_pwm;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic [31:0] c, l, p, cm,
    input int k,
    input logic [31:0] ec, es,
    input logic ei, ep
  );
    vec_t v;
    v.ctrl = c; v.load = l; v.psc = p; v.cmp = cm;
    v.k = k; v.e_cnt = ec; v.e_st = es;
    v.e_irq = ei; v.e_pwm = ep;
    return v;
  endfunction

  logic [NR-1:0] pend_wr;
  logic [31:0]   exp_st;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    regs_in = '0;
    reg_wr = '0;
    pend_wr = '0;

    // k = clock edges after CTRL is presented
    vt.push_back(mk(32'h5, 5, 0, 0, 1, 5, 32'h6, 0, 0));
    vt.push_back(mk(32'h5, 5, 0, 0, 4, 2, 32'h6, 0, 0));
    vt.push_back(mk(32'h5, 5, 0, 0, 6, 0, 32'h6, 0, 0));
    vt.push_back(mk(32'h5, 5, 0, 0, 7, 0, 32'h9, 1, 0));
    vt.push_back(mk(32'h5, 5, 0, 0, 10, 0, 32'h9, 1, 0));
    vt.push_back(mk(32'h1, 2, 0, 0, 4, 0, 32'h9, 0, 0));
    vt.push_back(mk(32'h5, 3, 2, 0, 6, 2, 32'h6, 0, 0));
    vt.push_back(mk(32'h5, 3, 2, 0, 12, 0, 32'h6, 0, 0));
    vt.push_back(mk(32'h5, 3, 2, 0, 13, 0, 32'h9, 1, 0));
    vt.push_back(mk(32'hB, 9, 0, 4, 7, 3, 32'h6, 0, 0));
    vt.push_back(mk(32'hB, 9, 0, 4, 8, 2, 32'h6, 0, 1));
    vt.push_back(mk(32'hB, 9, 0, 4, 11, 9, 32'h7, 0, 1));
    vt.push_back(mk(32'hB, 9, 0, 4, 12, 8, 32'h7, 0, 0));
    vt.push_back(mk(32'hB, 9, 0, 0, 9, 1, 32'h6, 0, 0));
    vt.push_back(mk(32'hB, 9, 0, 100, 2, 8, 32'h6, 0, 1));
    vt.push_back(mk(32'h4, 5, 0, 0, 3, 0, 32'h0, 0, 0));

    do_reset();
    chk("rst_count", count_out, 0);
    chk("rst_status", status_out, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    chk("rst_pwm", {31'd0, pwm_out}, 0);

    foreach (vt[j]) begin
      do_reset();
      set_regs(vt[j].ctrl, vt[j].load, vt[j].psc, vt[j].cmp);
      rst = 1'b1;
      for (int i = 0; i < vt[j].k; i++) begin
        @(negedge clk);
        reg_wr = (i == 0) ? 8'h0F : 8'h00;
      end
      chk($sformatf("v%0d_count", j), count_out, vt[j].e_cnt);
      chk($sformatf("v%0d_status", j), status_out, vt[j].e_st);
      chk($sformatf("v%0d_irq", j), {31'd0, irq}, {31'd0, vt[j].e_irq});
      chk($sformatf("v%0d_pwm", j), {31'd0, pwm_out}, {31'd0, vt[j].e_pwm});
    end

    // Clear pulse lands on the expiry edge.
    do_reset();
    set_regs(32'h5, 2, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("clr_pre_count", count_out, 0);
    regs_in[31:0] = 32'h15;
    reg_wr = 8'h01;
    @(negedge clk);
    reg_wr = 8'h00;
    chk("clr_vs_expiry_status", status_out, 32'h9);
    chk("clr_vs_expiry_irq", {31'd0, irq}, 1);
    reg_wr = 8'h01;
    @(negedge clk);
    reg_wr = 8'h00;
    chk("clr_status", status_out, 32'h8);
    chk("clr_irq", {31'd0, irq}, 0);

    // Masking keeps pending visible.
    do_reset();
    set_regs(32'h5, 1, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mask_pre_irq", {31'd0, irq}, 1);
    regs_in[31:0] = 32'h1;
    #1;
    chk("mask_irq", {31'd0, irq}, 0);
    chk("mask_status", status_out, 32'h9);

    // Auto-reload period and clear between expiries.
    do_reset();
    set_regs(32'h7, 3, 2, 0);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("ar_before_irq", {31'd0, irq}, 0);
    @(negedge clk);
    chk("ar_first_irq", {31'd0, irq}, 1);
    @(negedge clk);
    regs_in[31:0] = 32'h17;
    reg_wr = 8'h01;
    @(negedge clk);
    reg_wr = 8'h00;
    chk("ar_clr_irq", {31'd0, irq}, 0);
    chk("ar_clr_status", status_out, 32'h6);
    repeat (9) @(negedge clk);
    chk("ar_gap_irq", {31'd0, irq}, 0);
    @(negedge clk);
    chk("ar_second_irq", {31'd0, irq}, 1);

    // Pause holds the count; re-enable reloads.
    do_reset();
    set_regs(32'h1, 20, 0, 0);
    rst = 1'b1;
    repeat (14) @(negedge clk);
    chk("pause_pre_count", count_out, 7);
    regs_in[31:0] = 32'h0;
    @(negedge clk);
    chk("pause_status", status_out, 0);
    chk("pause_count", count_out, 7);
    repeat (3) @(negedge clk);
    chk("pause_hold_count", count_out, 7);
    regs_in[63:32] = 32'd30;
    regs_in[31:0] = 32'h1;
    @(negedge clk);
    chk("reen_count", count_out, 30);
    chk("reen_status", status_out, 32'h6);

    // Reset in the middle of a run.
    do_reset();
    set_regs(32'hF, 2, 0, 1000);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_pre_irq", {31'd0, irq}, 1);
    chk("mid_pre_pwm", {31'd0, pwm_out}, 1);
    chk("mid_pre_status", status_out, 32'h7);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", count_out, 0);
    chk("mid_rst_status", status_out, 0);
    chk("mid_rst_irq", {31'd0, irq}, 0);
    chk("mid_rst_pwm", {31'd0, pwm_out}, 0);

    // Random traffic against the reference model.
    do_reset();
    set_regs(32'h7, 4, 1, 3);
    rst = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      exp_st = {28'd0, m.st, (m.st == 2'd1), m.pend};
      chk("rnd_count", count_out, m.cnt);
      chk("rnd_status", status_out, exp_st);
      chk("rnd_irq", {31'd0, irq},
          {31'd0, m.pend & regs_in[2]});
      chk("rnd_pwm", {31'd0, pwm_out}, {31'd0, m.pwm});
      reg_wr = pend_wr;
      pend_wr = '0;
      rst = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 5) == 0) begin
        int w;
        logic [31:0] v;
        w = $urandom_range(0, NR - 1);
        v = $urandom;
        case (w)
          0: begin
            v = v & 32'h1F;
            v[0] = ($urandom_range(0, 3) != 0);
          end
          1: v = $urandom_range(0, 12);
          2: v = $urandom_range(0, 3);
          3: v = $urandom_range(0, 14);
          default: ;
        endcase
        regs_in[w*32 +: 32] = v;
        pend_wr[w] = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
